// File: rtl/r5p_tcb_arb_pkg.sv
// Shared types for the R5P TCB two-manager arbiter: owner-pipeline entry,
// TCB request/response payloads and the supported response-delay limit.
package r5p_tcb_arb_pkg;

  localparam int unsigned ARB_DLY_MAX = 4;

  typedef struct packed {
    logic vld;
    logic own;
  } arb_own_t;

  typedef struct packed {
    logic        cmd;
    logic        wen;
    logic        ndn;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
  } tcb_req_t;

  typedef struct packed {
    logic err;
  } tcb_sts_t;

  typedef struct packed {
    logic [31:0] rdt;
    tcb_sts_t    sts;
  } tcb_rsp_t;

endpackage

// File: rtl/tcb_if.sv
// TCB bus bundle. Handshake: a transfer (trn) happens in every cycle where
// vld & rdy; req is stable while vld is held, rsp returns a fixed delay later.
interface tcb_if;
  import r5p_tcb_arb_pkg::*;

  logic     vld;
  logic     rdy;
  logic     trn;
  tcb_req_t req;
  tcb_rsp_t rsp;

  assign trn = vld & rdy;

  modport man (output vld, output req, input rdy, input rsp, input trn);
  modport sub (input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/r5p_tcb_arb_dly.sv
// Owner delay line: DLY stages of {valid, owner}, pass-through when DLY == 0.
// Asynchronous active-low reset flushes every stage.
module r5p_tcb_arb_dly
  import r5p_tcb_arb_pkg::*;
#(
  parameter int unsigned DLY = 1
)(
  input  logic     clk,
  input  logic     rst,
  input  arb_own_t i_own,
  output arb_own_t o_own
);

  if (DLY > ARB_DLY_MAX) begin : g_chk
    $error("r5p_tcb_arb_dly: DLY out of range");
  end

  if (DLY == 0) begin : g_pass
    assign o_own = i_own;
  end else begin : g_pipe
    arb_own_t r_pipe [DLY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_own;
        for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_own = r_pipe[DLY-1];
  end

endmodule

// File: rtl/r5p_tcb_arb.sv
// Two-manager to one-subordinate TCB arbiter (s0 = lsb, s1 = ifb).
// Define R5P_TCB_ARB_RR_EN for round-robin; otherwise port PRI has fixed priority.
module r5p_tcb_arb
  import r5p_tcb_arb_pkg::*;
#(
  parameter int unsigned DLY = 1,
  parameter bit          PRI = 1'b0
)(
  input  logic clk,
  input  logic rst,
  tcb_if.sub   s0,
  tcb_if.sub   s1,
  tcb_if.man   m,
  output logic gnt,
  output logic lck
);

  logic     r_gnt;
  logic     r_lck;
  logic     w_gnt;
  logic     w_tie;
  arb_own_t w_own_in;
  arb_own_t w_own;

`ifdef R5P_TCB_ARB_RR_EN
  // Pointer holds the last-served port; the other port wins a tie.
  logic r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_ptr <= 1'b0;
    else if (m.trn) r_ptr <= w_gnt;
  end

  assign w_tie = ~r_ptr;
`else
  assign w_tie = PRI;
`endif

  always_comb begin
    w_gnt = r_gnt;
    if (!r_lck) begin
      case ({s1.vld, s0.vld})
        2'b01:   w_gnt = 1'b0;
        2'b10:   w_gnt = 1'b1;
        2'b11:   w_gnt = w_tie;
        default: w_gnt = r_gnt;
      endcase
    end
  end

  // Lock covers a stalled handshake; it also drops if a manager abandons vld.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt <= 1'b0;
      r_lck <= 1'b0;
    end else begin
      r_gnt <= w_gnt;
      r_lck <= m.vld & ~m.rdy;
    end
  end

  assign m.vld  = w_gnt ? s1.vld : s0.vld;
  assign m.req  = w_gnt ? s1.req : s0.req;
  assign s0.rdy = ~w_gnt & m.rdy;
  assign s1.rdy =  w_gnt & m.rdy;

  assign w_own_in.vld = m.trn;
  assign w_own_in.own = w_gnt;

  r5p_tcb_arb_dly #(
    .DLY (DLY)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .i_own (w_own_in),
    .o_own (w_own)
  );

  assign s0.rsp = (w_own.vld && !w_own.own) ? m.rsp : '0;
  assign s1.rsp = (w_own.vld &&  w_own.own) ? m.rsp : '0;

  assign gnt = w_gnt;
  assign lck = r_lck;

endmodule

// File: tb/tb_r5p_tcb_arb.sv
// Directed bench for r5p_tcb_arb: three instances (DLY 0, 1, 2) share one
// request stimulus; each has its own fixed-delay memory model.
module tb_r5p_tcb_arb;
  import r5p_tcb_arb_pkg::*;

`ifdef R5P_TCB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        v0, v1, mrdy;
  logic [31:0] a0, a1;
  tcb_req_t    rq0, rq1;
  logic        gnt0, lck0, gnt1, lck1, gnt2, lck2;
  tcb_rsp_t    r_m1, r_m2a, r_m2b;
  int          n_vec;
  int          n_err;

  function automatic tcb_req_t mk_req(input logic [31:0] adr, input logic wen);
    tcb_req_t r;
    r.cmd = 1'b1;
    r.wen = wen;
    r.ndn = 1'b0;
    r.adr = adr;
    r.ben = 4'hf;
    r.wdt = ~adr;
    return r;
  endfunction

  function automatic tcb_rsp_t mem_rsp(input logic [31:0] adr);
    tcb_rsp_t r;
    r.rdt     = 32'hA5A5_0000 + adr;
    r.sts.err = adr[4];
    return r;
  endfunction

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rq0 = mk_req(a0, 1'b1);
  assign rq1 = mk_req(a1, 1'b0);

  tcb_if s0_0 (); tcb_if s1_0 (); tcb_if m_0 ();
  tcb_if s0_1 (); tcb_if s1_1 (); tcb_if m_1 ();
  tcb_if s0_2 (); tcb_if s1_2 (); tcb_if m_2 ();

  assign s0_0.vld = v0;  assign s0_0.req = rq0;
  assign s1_0.vld = v1;  assign s1_0.req = rq1;
  assign s0_1.vld = v0;  assign s0_1.req = rq0;
  assign s1_1.vld = v1;  assign s1_1.req = rq1;
  assign s0_2.vld = v0;  assign s0_2.req = rq0;
  assign s1_2.vld = v1;  assign s1_2.req = rq1;
  assign m_0.rdy = mrdy;
  assign m_1.rdy = mrdy;
  assign m_2.rdy = mrdy;

  // memory models with 0, 1 and 2 cycles of response delay
  assign m_0.rsp = mem_rsp(m_0.req.adr);
  always @(posedge clk) begin
    r_m1  <= mem_rsp(m_1.req.adr);
    r_m2a <= mem_rsp(m_2.req.adr);
    r_m2b <= r_m2a;
  end
  assign m_1.rsp = r_m1;
  assign m_2.rsp = r_m2b;

  r5p_tcb_arb #(.DLY(0), .PRI(1'b0)) u_dut0 (
    .clk (clk), .rst (rst_n), .s0 (s0_0), .s1 (s1_0), .m (m_0), .gnt (gnt0), .lck (lck0)
  );
  r5p_tcb_arb #(.DLY(1), .PRI(1'b0)) u_dut (
    .clk (clk), .rst (rst_n), .s0 (s0_1), .s1 (s1_1), .m (m_1), .gnt (gnt1), .lck (lck1)
  );
  r5p_tcb_arb #(.DLY(2), .PRI(1'b0)) u_dut2 (
    .clk (clk), .rst (rst_n), .s0 (s0_2), .s1 (s1_2), .m (m_2), .gnt (gnt2), .lck (lck2)
  );

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; mrdy = 1'b1; a0 = '0; a1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_vec++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt: got %0h want 0", gnt1); end
    n_vec++; if (lck1 !== 1'b0) begin n_err++; $display("FAIL rst_lck: got %0h want 0", lck1); end
    n_vec++; if (m_1.vld !== 1'b0) begin n_err++; $display("FAIL rst_mvld: got %0h want 0", m_1.vld); end
    n_vec++; if (s0_1.rsp !== '0) begin n_err++; $display("FAIL rst_s0rsp: got %h want 0", s0_1.rsp); end
    n_vec++; if (s1_1.rsp !== '0) begin n_err++; $display("FAIL rst_s1rsp: got %h want 0", s1_1.rsp); end
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; a0 = 32'h100; a1 = 32'h200;
    @(negedge clk); #1;
    n_vec++; if (lck1 !== 1'b0) begin n_err++; $display("FAIL rst_busy_lck: got %0h want 0", lck1); end
    n_vec++; if (s0_1.rsp !== '0) begin n_err++; $display("FAIL rst_busy_s0rsp: got %h want 0", s0_1.rsp); end
    n_vec++; if (s1_1.rsp !== '0) begin n_err++; $display("FAIL rst_busy_s1rsp: got %h want 0", s1_1.rsp); end
    @(negedge clk);
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b0;
    #1;
    n_vec++; if (m_1.vld !== 1'b1) begin n_err++; $display("FAIL rel_mvld: got %0h want 1", m_1.vld); end
    n_vec++; if (m_1.req.adr !== 32'h100) begin n_err++; $display("FAIL rel_madr: got %h want 00000100", m_1.req.adr); end
    n_vec++; if (s0_1.rdy !== 1'b1) begin n_err++; $display("FAIL rel_s0rdy: got %0h want 1", s0_1.rdy); end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    n_vec++; if (s0_1.rsp.rdt !== 32'hA5A5_0100) begin n_err++; $display("FAIL rel_s0rdt: got %h want a5a50100", s0_1.rsp.rdt); end
    n_vec++; if (s1_1.rsp.rdt !== 32'h0) begin n_err++; $display("FAIL rel_s1rdt: got %h want 0", s1_1.rsp.rdt); end
  endtask

  task automatic test_back_to_back();
    logic        exp_g, prev_g;
    logic [31:0] exp_adr, prev_adr;
    tcb_rsp_t    exp0, exp1;
    prev_g = 1'b0; prev_adr = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      v0 = (i < 8); v1 = (i < 8); mrdy = 1'b1;
      a0 = 32'h1000 + 32'(i) * 16;
      a1 = 32'h2000 + 32'(i) * 16;
      #1;
      // pointer enters at 0 (last served s0), so s1 wins the first tie
      exp_g   = RR ? ~i[0] : 1'b0;
      exp_adr = exp_g ? a1 : a0;
      if (i < 8) begin
        n_vec++; if (gnt1 !== exp_g) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %0h want %0h", i, gnt1, exp_g); end
        n_vec++; if (s1_1.rdy !== exp_g) begin n_err++; $display("FAIL b2b_s1rdy[%0d]: got %0h want %0h", i, s1_1.rdy, exp_g); end
        n_vec++; if (m_1.req !== (exp_g ? rq1 : rq0)) begin n_err++; $display("FAIL b2b_mreq[%0d]: got %h want %h", i, m_1.req, exp_g ? rq1 : rq0); end
        exp0 = '0; exp1 = '0;
        if (exp_g) exp1 = mem_rsp(exp_adr); else exp0 = mem_rsp(exp_adr);
        n_vec++; if (s0_0.rsp !== exp0) begin n_err++; $display("FAIL d0_s0rsp[%0d]: got %h want %h", i, s0_0.rsp, exp0); end
        n_vec++; if (s1_0.rsp !== exp1) begin n_err++; $display("FAIL d0_s1rsp[%0d]: got %h want %h", i, s1_0.rsp, exp1); end
      end
      if (i > 0) begin
        exp0 = '0; exp1 = '0;
        if (prev_g) exp1 = mem_rsp(prev_adr); else exp0 = mem_rsp(prev_adr);
        n_vec++; if (s0_1.rsp !== exp0) begin n_err++; $display("FAIL b2b_s0rsp[%0d]: got %h want %h", i, s0_1.rsp, exp0); end
        n_vec++; if (s1_1.rsp !== exp1) begin n_err++; $display("FAIL b2b_s1rsp[%0d]: got %h want %h", i, s1_1.rsp, exp1); end
      end
      prev_g = exp_g; prev_adr = exp_adr;
    end
  endtask

  task automatic test_lock();
    // {v0, v1, m.rdy, expected gnt, expected lck}
    logic [4:0] tbl [6];
    tbl = '{5'b01010, 5'b01011, 5'b11011, 5'b11111, 5'b10100, 5'b00100};
    a0 = 32'h400; a1 = 32'h300;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      v0 = tbl[c][4]; v1 = tbl[c][3]; mrdy = tbl[c][2];
      #1;
      n_vec++; if (gnt1 !== tbl[c][1]) begin n_err++; $display("FAIL lck_gnt[%0d]: got %0h want %0h", c, gnt1, tbl[c][1]); end
      n_vec++; if (lck1 !== tbl[c][0]) begin n_err++; $display("FAIL lck_lck[%0d]: got %0h want %0h", c, lck1, tbl[c][0]); end
      n_vec++; if (s0_1.rdy !== (~tbl[c][1] & tbl[c][2])) begin n_err++; $display("FAIL lck_s0rdy[%0d]: got %0h want %0h", c, s0_1.rdy, ~tbl[c][1] & tbl[c][2]); end
      if (c == 4) begin
        n_vec++; if (s1_1.rsp.rdt !== 32'hA5A5_0300) begin n_err++; $display("FAIL lck_s1rdt: got %h want a5a50300", s1_1.rsp.rdt); end
      end
      if (c == 5) begin
        n_vec++; if (s0_1.rsp.rdt !== 32'hA5A5_0400) begin n_err++; $display("FAIL lck_s0rdt: got %h want a5a50400", s0_1.rsp.rdt); end
      end
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b0; mrdy = 1'b1; a0 = 32'h600; a1 = 32'h500;
    #1;
    n_vec++; if (gnt2 !== 1'b0) begin n_err++; $display("FAIL fl_gnt0: got %0h want 0", gnt2); end
    @(negedge clk);
    v0 = 1'b0;
    #1;
    n_vec++; if (s0_2.rsp !== '0) begin n_err++; $display("FAIL fl_early: got %h want 0", s0_2.rsp); end
    @(negedge clk);
    v1 = 1'b1;
    #1;
    n_vec++; if (s0_2.rsp.rdt !== 32'hA5A5_0600) begin n_err++; $display("FAIL fl_d2rdt: got %h want a5a50600", s0_2.rsp.rdt); end
    n_vec++; if (gnt2 !== 1'b1) begin n_err++; $display("FAIL fl_gnt1: got %0h want 1", gnt2); end
    @(negedge clk);
    rst_n = 1'b0; v1 = 1'b0;
    #1;
    n_vec++; if (gnt2 !== 1'b0) begin n_err++; $display("FAIL fl_rst_gnt: got %0h want 0", gnt2); end
    n_vec++; if (s1_2.rsp !== '0) begin n_err++; $display("FAIL fl_rst_s1rsp: got %h want 0", s1_2.rsp); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (s1_2.rsp !== '0) begin n_err++; $display("FAIL fl_drop_s1: got %h want 0", s1_2.rsp); end
    n_vec++; if (s0_2.rsp !== '0) begin n_err++; $display("FAIL fl_drop_s0: got %h want 0", s0_2.rsp); end
    n_vec++; if (gnt2 !== 1'b0) begin n_err++; $display("FAIL fl_rel_gnt: got %0h want 0", gnt2); end
    n_vec++; if (lck2 !== 1'b0) begin n_err++; $display("FAIL fl_rel_lck: got %0h want 0", lck2); end
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    n_vec++; if (gnt2 !== RR) begin n_err++; $display("FAIL fl_fresh_gnt: got %0h want %0h", gnt2, RR); end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_lock();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
